// File: rtl/gslcd_pkg.sv
// Shared types and constants for the gslcd framebuffer fetch path.
package gslcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } fb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_AR_CACHE   = 4'b0011;
    localparam logic [2:0] AXI_AR_PROT    = 3'b000;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gslcd_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO with flush and free-count.
// Read data comes straight from the storage array, so a written word is
// visible one cycle after the push.
module gslcd_pixel_fifo
    import gslcd_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic [clog2(DEPTH):0] free
);
    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign free     = DEPTH_CNT - count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update; flush discards all stored words.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/gslcd_fb_reader.sv
// Framebuffer fetch stage: AXI4 burst-read master that walks one frame of
// 0x00RRGGBB pixels and presents them as a valid/ready RGB888 stream.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no frame in progress, waiting for an enabled frame start
// ST_ADDR  | waiting for FIFO room, then presenting the next AR burst
// ST_DATA  | accepting beats of the outstanding burst into the FIFO
// ST_DRAIN | frame restarted: discard rest of the outstanding burst
module gslcd_fb_reader
    import gslcd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 384000,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] io_baseAddr,
    input  logic                  io_enable,
    input  logic                  io_frameStart,
    output logic                  io_pixel_valid,
    input  logic                  io_pixel_ready,
    output logic [23:0]           io_pixel_payload,
    output logic                  io_busy,
    output logic                  io_error,
    output logic                  io_ar_valid,
    input  logic                  io_ar_ready,
    output logic [ADDR_WIDTH-1:0] io_ar_addr,
    output logic [7:0]            io_ar_len,
    output logic [2:0]            io_ar_size,
    output logic [1:0]            io_ar_burst,
    output logic [3:0]            io_ar_cache,
    output logic [2:0]            io_ar_prot,
    output logic [3:0]            io_ar_id,
    input  logic                  io_r_valid,
    output logic                  io_r_ready,
    input  logic [DATA_WIDTH-1:0] io_r_data,
    input  logic [1:0]            io_r_resp,
    input  logic                  io_r_last,
    input  logic [3:0]            io_r_id
);
    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int NUM_BURSTS  = FRAME_WORDS / BURST_LEN;
    localparam int BEAT_W      = clog2(BURST_LEN);
    localparam int BURST_W     = (clog2(NUM_BURSTS) > 0) ? clog2(NUM_BURSTS) : 1;
    localparam int FREE_W      = clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BURST_BYTES - 1));
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]    LAST_BURST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [FREE_W-1:0]     RESERVE    = FREE_W'(BURST_LEN);

    fb_state_t             state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BURST_W-1:0]    burst_cnt;
    logic                  ar_valid_q;
    logic                  r_ready_q;
    logic                  error_q;

    logic [ADDR_WIDTH-1:0] new_base;
    logic [ADDR_WIDTH-1:0] next_base;
    logic                  restart;
    logic                  r_beat;
    logic                  last_beat;
    logic                  fifo_push;
    logic                  fifo_flush;
    logic                  fifo_empty;
    logic [FREE_W-1:0]     fifo_free;
    logic                  unused_inputs;

    // Bursts are aligned to their own size so a burst never crosses 4 KB.
    assign new_base  = io_baseAddr & ALIGN_MASK;
    assign restart   = io_frameStart && io_enable && (state != ST_IDLE);
    assign next_base = restart ? new_base : base_q;
    assign r_beat    = io_r_valid && r_ready_q;
    assign last_beat = (beat_cnt == LAST_BEAT);
    // A beat arriving in the restart cycle belongs to the old frame and is dropped.
    assign fifo_push  = r_beat && (state == ST_DATA) && !restart;
    assign fifo_flush = restart || ((state == ST_DRAIN) && r_beat && last_beat);

    gslcd_pixel_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (io_r_data[23:0]),
        .pop       (io_pixel_ready),
        .pop_data  (io_pixel_payload),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    // Fetch sequencer: AR issue, beat/burst counting, restart and error tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            ar_addr_q  <= '0;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (restart) begin
                base_q  <= new_base;
                error_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (io_frameStart && io_enable) begin
                        base_q    <= new_base;
                        ar_addr_q <= new_base;
                        burst_cnt <= '0;
                        beat_cnt  <= '0;
                        error_q   <= 1'b0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (restart) begin
                        beat_cnt <= '0;
                        if (ar_valid_q) begin
                            // An AR already presented must complete; its data is discarded.
                            if (io_ar_ready) ar_valid_q <= 1'b0;
                            r_ready_q <= 1'b1;
                            state     <= ST_DRAIN;
                        end else begin
                            ar_addr_q <= new_base;
                            burst_cnt <= '0;
                        end
                    end else if (ar_valid_q) begin
                        if (io_ar_ready) begin
                            ar_valid_q <= 1'b0;
                            r_ready_q  <= 1'b1;
                            beat_cnt   <= '0;
                            state      <= ST_DATA;
                        end
                    end else if (fifo_free >= RESERVE) begin
                        ar_valid_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_beat) begin
                        if (!restart && ((io_r_last != last_beat) ||
                                         (io_r_resp != AXI_RESP_OKAY))) begin
                            error_q <= 1'b1;
                        end
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                    if (restart) begin
                        if (r_beat && last_beat) begin
                            r_ready_q <= 1'b0;
                            ar_addr_q <= new_base;
                            burst_cnt <= '0;
                            state     <= ST_ADDR;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (r_beat && last_beat) begin
                        r_ready_q <= 1'b0;
                        burst_cnt <= burst_cnt + 1'b1;
                        ar_addr_q <= ar_addr_q + BURST_STEP;
                        state     <= (burst_cnt == LAST_BURST) ? ST_IDLE : ST_ADDR;
                    end
                end
                ST_DRAIN: begin
                    if (ar_valid_q && io_ar_ready) ar_valid_q <= 1'b0;
                    if (r_beat) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                        if (last_beat) begin
                            r_ready_q <= 1'b0;
                            ar_addr_q <= next_base;
                            burst_cnt <= '0;
                            state     <= ST_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io_pixel_valid = !fifo_empty;
    assign io_busy        = (state != ST_IDLE);
    assign io_error       = error_q;
    assign io_ar_valid    = ar_valid_q;
    assign io_ar_addr     = ar_addr_q;
    assign io_ar_len      = 8'(BURST_LEN - 1);
    assign io_ar_size     = 3'(clog2(BEAT_BYTES));
    assign io_ar_burst    = AXI_BURST_INCR;
    assign io_ar_cache    = AXI_AR_CACHE;
    assign io_ar_prot     = AXI_AR_PROT;
    assign io_ar_id       = '0;
    assign io_r_ready     = r_ready_q;

    // Only one ID is ever issued and the alpha byte is not displayed.
    assign unused_inputs = ^{io_r_id, io_r_data[DATA_WIDTH-1:24]};

endmodule
